// File: rtl/pc_clk_pkg.sv
// Shared definitions for the PC clock generator: FSM state encoding and the
// mode codes presented on the mode input.
package pc_clk_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  // Code 2'b11 is deliberately not named: it behaves exactly like MODE_HALT.

endpackage

// File: rtl/pc_clk_gen_if.sv
// Control/status bundle of the PC clock generator.
//   mode, step_req            : run control (master -> slave)
//   cfg_half, cfg_valid       : half-period reload request (master -> slave)
//   cfg_ready                 : reload slot free (slave -> master)
//   clk_out, rise_tick,
//   fall_tick, period_done,
//   busy                      : registered generator outputs (slave -> master)
interface pc_clk_gen_if #(
  parameter int DIV_W = 8
) ();
  logic [1:0]       mode;
  logic             step_req;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic             period_done;
  logic             busy;

  modport master (
    output mode, step_req, cfg_half, cfg_valid,
    input  cfg_ready, clk_out, rise_tick, fall_tick, period_done, busy
  );

  modport slave (
    input  mode, step_req, cfg_half, cfg_valid,
    output cfg_ready, clk_out, rise_tick, fall_tick, period_done, busy
  );
endinterface

// File: rtl/pc_clk_cfg_reg.sv
// Holding register for a half-period reload request.
//   clk, reset     : core clock, async active-high reset
//   cfg_half/valid : incoming request; accepted when the slot is empty
//   apply          : generator consumed the pending value this cycle
//   cfg_ready      : slot empty
//   pending_half/vld : held value and its valid flag
module pc_clk_cfg_reg #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_half,
  input  logic             cfg_valid,
  input  logic             apply,
  output logic             cfg_ready,
  output logic [DIV_W-1:0] pending_half,
  output logic             pending_vld
);

  logic             pending_vld_q, pending_vld_d;
  logic [DIV_W-1:0] pending_half_q, pending_half_d;
  logic             capture;

  // Capture and apply are mutually exclusive: capture needs an empty slot,
  // apply needs a full one.
  always_comb begin
    capture        = cfg_valid && !pending_vld_q;
    pending_vld_d  = pending_vld_q;
    pending_half_d = pending_half_q;
    if (capture) begin
      pending_vld_d  = 1'b1;
      pending_half_d = cfg_half;
    end else if (apply) begin
      pending_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_vld_q <= 1'b0;
    else       pending_vld_q <= pending_vld_d;
  end

  // The value is only meaningful while pending_vld_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pending_half_q <= pending_half_d;
  end

  assign cfg_ready    = !pending_vld_q;
  assign pending_half = pending_half_q;
  assign pending_vld  = pending_vld_q;

endmodule

// File: rtl/pc_clk_gen.sv
// Programmable divided-clock / clock-enable generator for the PC domain.
//   clk, reset : core clock, async active-high reset
//   bus        : pc_clk_gen_if slave port (mode/step control, half-period
//                reload handshake, registered clk_out and tick outputs)
// clk_out is high for max(half,1) cycles then low for the same count.
// A started period always runs to completion; reloads take effect only at
// period boundaries or while halted.
module pc_clk_gen
  import pc_clk_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int RESET_HALF = 4
) (
  input  logic         clk,
  input  logic         reset,
  pc_clk_gen_if.slave  bus
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_half_q, active_half_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_tick_q, rise_tick_d;
  logic             fall_tick_q, fall_tick_d;
  logic             period_done_q, period_done_d;
  logic             busy_q, busy_d;

  logic [DIV_W-1:0] pending_half;
  logic             pending_vld;
  logic             apply;
  logic             at_end;
  logic             boundary;
  logic             go;
  logic [DIV_W-1:0] start_m1;

  // Counter load value for a phase: max(h,1)-1, so full-scale h never wraps.
  function automatic logic [DIV_W-1:0] half_m1(input logic [DIV_W-1:0] h);
    return (h == '0) ? '0 : h - DIV_W'(1);
  endfunction

  pc_clk_cfg_reg #(.DIV_W(DIV_W)) u_cfg (
    .clk          (clk),
    .reset        (reset),
    .cfg_half     (bus.cfg_half),
    .cfg_valid    (bus.cfg_valid),
    .apply        (apply),
    .cfg_ready    (bus.cfg_ready),
    .pending_half (pending_half),
    .pending_vld  (pending_vld)
  );

  always_comb begin
    at_end   = (cnt_q == '0);
    boundary = (state_q == ST_LOW) && at_end;
    apply    = pending_vld && ((state_q == ST_HALT) || boundary);
    go       = (bus.mode == MODE_RUN) || ((bus.mode == MODE_STEP) && bus.step_req);
    // A period starting on the same edge a value is applied uses that value.
    start_m1 = apply ? half_m1(pending_half) : half_m1(active_half_q);

    state_d       = state_q;
    cnt_d         = cnt_q;
    active_half_d = apply ? pending_half : active_half_q;
    clk_out_d     = clk_out_q;
    rise_tick_d   = 1'b0;
    fall_tick_d   = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (go) begin
          state_d     = ST_HIGH;
          cnt_d       = start_m1;
          clk_out_d   = 1'b1;
          rise_tick_d = 1'b1;
        end
      end
      ST_HIGH: begin
        if (at_end) begin
          state_d     = ST_LOW;
          cnt_d       = half_m1(active_half_q);
          clk_out_d   = 1'b0;
          fall_tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (at_end) begin
          if (bus.mode == MODE_RUN) begin
            state_d     = ST_HIGH;
            cnt_d       = start_m1;
            clk_out_d   = 1'b1;
            rise_tick_d = 1'b1;
          end else begin
            state_d = ST_HALT;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = ST_HALT;
    endcase

    // Registered look-ahead so period_done and busy carry no input paths.
    period_done_d = (state_d == ST_LOW) && (cnt_d == '0);
    busy_d        = (state_d != ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HALT;
      cnt_q         <= '0;
      active_half_q <= DIV_W'(RESET_HALF);
      clk_out_q     <= 1'b0;
      rise_tick_q   <= 1'b0;
      fall_tick_q   <= 1'b0;
      period_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_half_q <= active_half_d;
      clk_out_q     <= clk_out_d;
      rise_tick_q   <= rise_tick_d;
      fall_tick_q   <= fall_tick_d;
      period_done_q <= period_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.clk_out     = clk_out_q;
  assign bus.rise_tick   = rise_tick_q;
  assign bus.fall_tick   = fall_tick_q;
  assign bus.period_done = period_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/pc_clk_gen.md
# pc_clk_gen

Programmable clock-enable and divided-clock generator that paces the program counter and other slow-domain logic from the core clock. Produces a registered, glitch-free divided square wave plus one-cycle rise/fall strobes. Supports free-run, halt and single-step modes, and runtime reload of the half-period through a valid/ready handshake applied only at period boundaries. Generalises the fixed divide-by-8 PC clock into a width-parametrised, reconfigurable block.

## Interface
- DIV_W, 8: width of the half-period setting and internal counter.
- RESET_HALF, 4: active half-period after reset, in clk cycles. Default gives period 8.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- mode  in  2  00 halt, 01 run, 10 step, 11 treated as halt.
- step_req  in  1  single-cycle pulse. Starts one period when in step mode and HALT.
- cfg_half  in  DIV_W  new half-period; 0 is treated as 1.
- cfg_valid  in  1  cfg_half valid.
- cfg_ready  out  1  high when no reload is pending.
- clk_out  out  1  divided clock, registered.
- rise_tick  out  1  high during the first cycle of each clk_out high phase.
- fall_tick  out  1  high during the first cycle of each clk_out low phase.
- period_done  out  1  high during the last cycle of each period (final LOW cycle).
- busy  out  1  state != HALT.

## Operation
- States are HALT, HIGH and LOW. Registers: down-counter cnt[DIV_W-1:0], active_half, pending_half, pending_vld.
- Reset values: state=HALT, clk_out=0, all ticks=0, busy=0, cfg_ready=1, active_half=RESET_HALF, pending_vld=0.
- HALT → HIGH when mode=run, or when mode=step and step_req=1.
  - Loads cnt=eff_half-1 and asserts rise_tick.
  - eff_half = max(active_half,1).
- HIGH: cnt decrements each cycle. At cnt==0 → LOW, reload cnt, assert fall_tick.
- LOW: cnt decrements. At cnt==0 the period ends and period_done=1.
  - If mode=run → HIGH, with reload and rise_tick.
  - Otherwise → HALT.
- A period, once started, always completes. Mode changes or halt mid-period never shorten a phase.
- step_req outside HALT, or while mode is not step, is ignored and not queued.
- Reload handshake:
  - cfg_valid & cfg_ready captures cfg_half into pending_half and sets pending_vld; cfg_ready falls the next cycle.
  - The pending value moves to active_half at a period boundary (LOW with cnt==0), or on the next cycle while in HALT.
  - Once the value is applied, pending_vld clears and cfg_ready rises the following cycle.
  - If capture and a boundary happen in the same cycle, the new value is not used for the period starting then; it applies at the next boundary.
- A reload to the current value is legal and has no visible effect.
- Reset mid-operation forces clk_out=0 and state=HALT asynchronously. Any pending reload is discarded.

## Timing
- Every output is registered, so there are no combinational paths from inputs to outputs.
- mode=run sampled in HALT at edge t: clk_out=1 and rise_tick=1 from t+1.
- clk_out is high for exactly eff_half cycles, then low for exactly eff_half cycles. Period = 2·eff_half.
- rise_tick, fall_tick and period_done are each exactly 1 cycle wide.
- With eff_half=1, clk_out toggles every cycle and the tick pulses coincide with phase cycles.
- A full-scale cfg_half (2^DIV_W−1) has no wrap issues, because the counter loads eff_half−1.

## Structure
- Shared package pc_clk_pkg:
  - State encoding localparams ST_HALT, ST_HIGH, ST_LOW.
  - Mode codes MODE_HALT, MODE_RUN, MODE_STEP.
- Optional sub-module pc_clk_cfg_reg holds the pending_half/pending_vld handshake register. The FSM and counter stay in pc_clk_gen.
- Expected size is about 150–250 lines.

## Test plan
- Reset, then mode=run with defaults → clk_out pattern 1111 0000 repeating; rise_tick every 8 cycles.
- cfg_half=0 loaded in HALT, then run → clk_out toggles every cycle (period 2).
- Running with half 4, load cfg_half=2 during the HIGH phase:
  - The current period finishes 4/4, then periods run 2/2.
  - cfg_ready is low from capture until one cycle after the boundary.
- mode=step with one step_req pulse → exactly one 4-high/4-low period, then HALT with busy=0. A second step_req mid-period produces no extra period.
- Switch mode to halt on the 2nd HIGH cycle → the period completes in full (4 high, 4 low), period_done fires, then clk_out stays 0.
- Assert reset on the 3rd HIGH cycle → clk_out, ticks and busy go to 0 immediately. After release with mode=run, the period restarts with RESET_HALF.
